// File: rtl/gan_pkg.sv
// Shared constants and types for the GAN output path.
// Frame layout: nine clamped pixels followed by the raw discriminator word.
package gan_pkg;

    localparam int WIDTH   = 32;
    localparam int FRAC    = 16;
    localparam int N_PIX   = 9;
    localparam int N_WORDS = 10;
    localparam int IDX_W   = 4;

    localparam logic [WIDTH-1:0] FIX_ONE = WIDTH'(1) << FRAC;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

endpackage

// File: rtl/gan_pix_clamp.sv
// Combinational clamp of one signed fixed-point word into [0, 1.0].
module gan_pix_clamp #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

    always_comb begin
        y = x;
        if (x[WIDTH-1]) begin
            y = '0;
        end else if ($signed(x) > ONE) begin
            y = ONE;
        end
    end

endmodule

// File: rtl/gan_frame_serializer.sv
// Captures one 3x3 GAN frame plus discriminator score and streams it out
// as ten words over valid/ready, counting sent frames and refused captures.
module gan_frame_serializer #(
    parameter int WIDTH  = gan_pkg::WIDTH,
    parameter int FRAC   = gan_pkg::FRAC,
    parameter int THRESH = 0,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cap_valid,
    output logic                          cap_ready,
    input  logic [gan_pkg::N_PIX*WIDTH-1:0] pix_in,
    input  logic [WIDTH-1:0]              disc_in,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [3:0]                    out_idx,
    output logic                          real_flag,
    output logic [CNT_W-1:0]              frame_cnt,
    output logic [CNT_W-1:0]              drop_cnt
);

    import gan_pkg::*;

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_WORDS - 1);
    localparam logic signed [WIDTH-1:0] THRESH_W = WIDTH'(THRESH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   buf_q [N_WORDS];
    logic [WIDTH-1:0]   buf_d [N_WORDS];
    logic [WIDTH-1:0]   clamped [N_PIX];
    logic [IDX_W-1:0]   idx_q, idx_d, idx_inc;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               real_q, real_d;
    logic [CNT_W-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    for (genvar k = 0; k < N_PIX; k++) begin : g_clamp
        gan_pix_clamp #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC)
        ) u_clamp (
            .x (pix_in[k*WIDTH +: WIDTH]),
            .y (clamped[k])
        );
    end

    assign idx_inc = idx_q + IDX_W'(1);

    // out_data is a register, so the next word is preloaded on each handshake.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        data_d  = data_q;
        real_d  = real_q;
        frame_d = frame_q;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE: begin
                if (cap_valid) begin
                    for (int unsigned k = 0; k < N_PIX; k++) begin
                        buf_d[k] = clamped[k];
                    end
                    buf_d[N_PIX] = disc_in;
                    real_d  = ($signed(disc_in) >= THRESH_W);
                    data_d  = clamped[0];
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (cap_valid && (drop_q != '1)) begin
                    drop_d = drop_q + CNT_W'(1);
                end
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        data_d  = '0;
                        frame_d = frame_q + CNT_W'(1);
                    end else begin
                        idx_d  = idx_inc;
                        data_d = buf_q[idx_inc];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int unsigned k = 0; k < N_WORDS; k++) begin
                buf_q[k] <= '0;
            end
            idx_q   <= '0;
            data_q  <= '0;
            real_q  <= 1'b0;
            frame_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            real_q  <= real_d;
            frame_q <= frame_d;
            drop_q  <= drop_d;
        end
    end

    assign cap_ready = (state_q == IDLE);
    assign out_valid = (state_q == SEND);
    assign out_last  = (state_q == SEND) && (idx_q == LAST_IDX);
    assign out_idx   = idx_q;
    assign out_data  = data_q;
    assign real_flag = real_q;
    assign frame_cnt = frame_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_gan_frame_serializer.sv
// Directed bench for gan_frame_serializer: a scoreboard of expected words is
// filled at capture time and drained by a monitor on each accepted word.
module tb_gan_frame_serializer;

    localparam int W  = 32;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cap_valid = 1'b0;
    logic            cap_ready;
    logic [9*W-1:0]  pix_in = '0;
    logic [W-1:0]    disc_in = '0;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            out_last;
    logic [3:0]      out_idx;
    logic            real_flag;
    logic [CW-1:0]   frame_cnt;
    logic [CW-1:0]   drop_cnt;

    gan_frame_serializer #(
        .WIDTH  (W),
        .FRAC   (16),
        .THRESH (0),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .pix_in    (pix_in),
        .disc_in   (disc_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .real_flag (real_flag),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  idx;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_assert = 0;
    int          n_fail   = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_clamp(input logic [31:0] x);
        if (x[31]) return 32'h0;
        if (x > 32'h0001_0000) return 32'h0001_0000;
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [31:0] p [9], input logic [31:0] d);
        exp_t x;
        for (int k = 0; k < 9; k++) begin
            x.data = model_clamp(p[k]);
            x.idx  = 4'(k);
            sb.push_back(x);
        end
        x.data = d;
        x.idx  = 4'd9;
        sb.push_back(x);
    endtask

    task automatic drive_frame(input logic [31:0] p [9], input logic [31:0] d);
        for (int k = 0; k < 9; k++) pix_in[k*32 +: 32] = p[k];
        disc_in = d;
    endtask

    task automatic capture(input logic [31:0] p [9], input logic [31:0] d);
        int n = 0;
        while (!cap_ready && n < 50) begin
            step();
            n++;
        end
        chk("cap_ready_wait", 32'(cap_ready), 32'd1);
        drive_frame(p, d);
        cap_valid = 1'b1;
        push_frame(p, d);
        step();
        cap_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((out_valid || sb.size() != 0) && n < 100) begin
            step();
            n++;
        end
        chk("frame_done", 32'(out_valid), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cap_valid = 1'b0;
        sb.delete();
        step();
        rst = 1'b0;
    endtask

    // Monitor: accepted words are checked against the scoreboard and a held
    // word must not change while the consumer stalls.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev && out_valid) begin
                chk("stall_data", out_data, prev_data);
                chk("stall_idx", 32'(out_idx), 32'(prev_idx));
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("word_data", out_data, e.data);
                    chk("word_idx", 32'(out_idx), 32'(e.idx));
                    chk("word_last", 32'(out_last), 32'(e.idx == 4'd9));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p1 [9];
        logic [31:0] p2 [9];
        logic [31:0] pr [9];
        logic [31:0] dr;
        int cyc, s3, s7, caps, n, last_n;

        p1 = '{32'hFFFF_FFFB, 32'h0, 32'h8000, 32'h1_0000, 32'h2_0000,
               32'h4000, 32'h1, 32'h7FFF_FFFF, 32'hC000};
        p2 = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500,
               32'h600, 32'h700, 32'h800, 32'h900};

        // Reset state
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_real_flag", 32'(real_flag), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_cap_ready", 32'(cap_ready), 32'd1);

        // Clamp frame, full throughput
        out_ready = 1'b1;
        capture(p1, 32'h3000);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_out_idx", 32'(out_idx), 32'd0);
        chk("lat_cap_ready", 32'(cap_ready), 32'd0);
        chk("lat_first_word", out_data, 32'd0);
        wait_idle();
        chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("t1_real_flag", 32'(real_flag), 32'd1);
        chk("t1_idle_data", out_data, 32'd0);

        // Backpressure on words 3 and 7
        capture(p2, 32'h1234);
        cyc = 0; s3 = 0; s7 = 0;
        while (out_valid && cyc < 60) begin
            cyc++;
            if (out_idx == 4'd3 && s3 < 4) begin
                out_ready = 1'b0;
                s3++;
            end else if (out_idx == 4'd7 && s7 < 4) begin
                out_ready = 1'b0;
                s7++;
            end else begin
                out_ready = 1'b1;
            end
            step();
        end
        out_ready = 1'b1;
        chk("bp_cycles", 32'(cyc), 32'd18);
        wait_idle();
        chk("bp_frame_cnt", 32'(frame_cnt), 32'd2);

        // Negative discriminator
        capture(p2, 32'hFFFF_FFFF);
        wait_idle();
        chk("neg_real_flag", 32'(real_flag), 32'd0);

        // cap_valid held for three frames
        do_reset();
        chk("rst2_real_flag", 32'(real_flag), 32'd0);
        chk("rst2_frame_cnt", 32'(frame_cnt), 32'd0);
        drive_frame(p2, 32'h55);
        cap_valid = 1'b1;
        caps = 0; n = 0; last_n = 0;
        while (n < 200) begin
            if (cap_ready) begin
                if (caps == 1) chk("hold_drop_f1", 32'(drop_cnt), 32'd10);
                if (caps == 2) chk("hold_drop_sat", 32'(drop_cnt), 32'd15);
                if (caps > 0) chk("hold_recapture", 32'(n - last_n), 32'd11);
                if (caps == 3) break;
                push_frame(p2, 32'h55);
                caps++;
                last_n = n;
            end
            step();
            n++;
        end
        cap_valid = 1'b0;
        chk("hold_caps", 32'(caps), 32'd3);
        chk("hold_frame_cnt", 32'(frame_cnt), 32'd3);
        chk("hold_drop_final", 32'(drop_cnt), 32'd15);
        chk("hold_sb_drained", 32'(sb.size()), 32'd0);

        // Reset in the middle of a frame
        capture(p1, 32'h77);
        n = 0;
        while (out_idx != 4'd5 && n < 20) begin
            step();
            n++;
        end
        chk("mid_reach_idx5", 32'(out_idx), 32'd5);
        do_reset();
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_out_idx", 32'(out_idx), 32'd0);
        chk("mid_out_data", out_data, 32'd0);
        chk("mid_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("mid_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("mid_cap_ready", 32'(cap_ready), 32'd1);
        capture(p2, 32'h88);
        wait_idle();
        chk("mid_new_frame_cnt", 32'(frame_cnt), 32'd1);

        // Frame counter wrap with random frames
        do_reset();
        for (int f = 0; f < 17; f++) begin
            for (int k = 0; k < 9; k++) pr[k] = $urandom;
            dr = $urandom;
            capture(pr, dr);
            wait_idle();
            chk("rand_real_flag", 32'(real_flag), 32'(!dr[31]));
        end
        chk("wrap_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("wrap_drop_cnt", 32'(drop_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gan_frame_serializer.md
Name: gan_frame_serializer

Overview:
- Sits directly downstream of the GAN top level.
- Captures one generated 3x3 frame (nine pixels) plus the discriminator score in a single cycle.
- Clamps pixels to the valid fixed-point range, tags the frame real/fake, and streams it out as 10 words over a valid/ready interface.
- Decouples the free-running combinational/pipelined GAN outputs from a slow consumer such as a UART or host bridge.

Parameters:
- WIDTH, 32, data word width; signed two's complement fixed-point.
- FRAC, 16, fractional bits; 1.0 = 1<<FRAC.
- THRESH, 0, signed discriminator threshold for the real flag.
- CNT_W, 16, width of the frame and drop counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cap_valid  in  1  GAN outputs stable; request capture.
- cap_ready  out  1  block can accept a capture.
- pix_in  in  9*WIDTH  signed pixels; slice k = pixel k (0=1x1 … 8=3x3, row-major).
- disc_in  in  WIDTH  signed discriminator output.
- out_data  out  WIDTH  streamed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts word.
- out_last  out  1  high with word 9 (final word).
- out_idx  out  4  index of current word, 0..9.
- real_flag  out  1  last captured disc_in >= THRESH.
- frame_cnt  out  CNT_W  frames fully sent.
- drop_cnt  out  CNT_W  captures refused while busy (saturating).

Behaviour:
- Reset (sync, active-high; clk and rst named as elsewhere in the codebase):
  - State IDLE; out_valid=0, out_last=0, out_idx=0, out_data=0.
  - real_flag=0, frame_cnt=0, drop_cnt=0, buffer cleared, cap_ready=1.
  - Reset mid-frame aborts the frame; no partial count.
- States:
  - IDLE: cap_ready=1, out_valid=0. On cap_valid=1, latch the buffer and go to SEND next cycle.
  - SEND: cap_ready=0, out_valid=1.
- Capture (IDLE and cap_valid):
  - buf[k] = clamp(pix_in slice k) for k=0..8; buf[9] = disc_in unclamped.
  - real_flag = (signed disc_in >= THRESH), registered.
  - Capture-to-first-valid latency: 1 cycle (out_valid high in the cycle after capture).
- Clamp (signed compare):
  - x < 0 -> 0.
  - x > (1<<FRAC) -> 1<<FRAC.
  - Otherwise x unchanged.
- SEND handshake:
  - out_data = buf[out_idx]; out_last = (out_idx==9).
  - out_valid, out_data and out_idx hold stable while out_ready=0.
  - On out_valid&out_ready with out_idx<9: out_idx increments next cycle.
  - On out_valid&out_ready with out_idx==9:
    - Return to IDLE; out_idx=0, out_valid=0.
    - frame_cnt+1, wrapping modulo 2^CNT_W.
  - Full throughput: with out_ready held high, one word per cycle; a frame occupies 10 SEND cycles plus 1 IDLE cycle minimum.
- Drops:
  - cap_valid=1 while in SEND: input ignored; drop_cnt+1, saturating at all-ones.
  - The buffer is never overwritten while in SEND.
- Simultaneous last handshake and cap_valid: counts as a drop (state is still SEND). Capture is possible on the following IDLE cycle.
- real_flag holds until the next capture.
- out_data is registered; no combinational path from inputs to outputs except cap_ready from state.

Decomposition:
- Shared package (gan_pkg):
  - WIDTH, FRAC.
  - N_PIX=9, N_WORDS=10.
  - FIX_ONE = 1<<FRAC.
  - State enum {IDLE, SEND}.
  - Index width constant (4).
- Sub-module gan_pix_clamp: combinational single-word clamp (WIDTH, FRAC), instantiated 9×.
- Counters and FSM stay in the top.

Test Plan:
- Reset, then capture with pix = {-5, 0, 0x8000, 0x10000, 0x20000, 0x4000, 1, 0x7FFFFFFF, 0xC000}, disc=0x3000, out_ready=1:
  - out_data sequence 0, 0, 0x8000, 0x10000, 0x10000, 0x4000, 1, 0x10000, 0xC000, 0x3000.
  - out_last only on word 9; frame_cnt=1; real_flag=1.
- Backpressure: out_ready low on words 3 and 7 for 4 cycles each -> out_data and out_idx stable during stalls; frame completes in 18 cycles; no duplicated or skipped words.
- disc_in = 0xFFFFFFFF (-1) with THRESH=0 -> real_flag=0; disc word streamed as 0xFFFFFFFF.
- cap_valid held high continuously for 3 frames:
  - Each frame captured on the IDLE cycle after last.
  - drop_cnt increments 10 per frame (9 SEND cycles plus the last-word cycle).
  - frame_cnt=3.
- Assert rst at out_idx=5 -> next cycle out_valid=0, out_idx=0, frame_cnt=0, drop_cnt=0; a new capture then streams from word 0.
- Preload frame_cnt near wrap with CNT_W=4: send 17 frames -> frame_cnt=1. Force 20 drops -> drop_cnt saturates at 15.
